// File: rtl/pkt_stream_pkg.sv
// Shared types for the packet stream register slice: framing error codes,
// skid buffer occupancy states and small framing helper functions.
package pkt_stream_pkg;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_NO_EOP = 2'd1,
      ERR_ORPHAN = 2'd2
   } pkt_err_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

   // A beat with no sop that arrives while no packet is open belongs to nothing
   function automatic logic is_orphan(input logic sop, input logic in_pkt);
      return ~sop & ~in_pkt;
   endfunction

   // A sop that arrives while a packet is still open means the old one lost its eop
   function automatic logic is_missing_eop(input logic sop, input logic in_pkt);
      return sop & in_pkt;
   endfunction

endpackage

// File: rtl/pkt_skid_stage.sv
// One fully registered 2-entry skid buffer. The main register drives the
// output; the skid register catches the beat accepted while the output stalls.
module pkt_skid_stage
   import pkt_stream_pkg::*;
#(
   parameter int WIDTH = 34
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             val_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_o,
   output logic             val_o,
   input  logic             ready_i
);

   skid_state_t      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             ready_q, ready_d;
   logic             push, pop;

   // Occupancy transitions and register loading for push/pop combinations
   always_comb begin
      push    = val_i & ready_q;
      pop     = (state_q != SKID_EMPTY) & ready_i;
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (push) begin
               main_d  = data_i;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (push && pop) begin
               main_d = data_i;
            end else if (push) begin
               skid_d  = data_i;
               state_d = SKID_TWO;
            end else if (pop) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            if (pop) begin
               main_d  = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      ready_d = (state_d != SKID_TWO);
   end

   // State, data and ready registers; ready stays low until the first clock after reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= SKID_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   assign ready_o = ready_q;
   assign val_o   = (state_q != SKID_EMPTY);
   assign data_o  = main_q;

endmodule

// File: rtl/pkt_stream_reg_slice.sv
// Register slice for the sop/eop/val/ready packet stream: a chain of skid
// stages plus an input framing checker and saturating packet/error counters.
module pkt_stream_reg_slice
   import pkt_stream_pkg::*;
#(
   parameter int DWIDTH       = 32,
   parameter int STAGES       = 2,
   parameter bit DROP_ORPHANS = 1'b0,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [DWIDTH-1:0]    data_i,
   input  logic                 sop_i,
   input  logic                 eop_i,
   input  logic                 val_i,
   output logic                 ready_o,
   output logic [DWIDTH-1:0]    data_o,
   output logic                 sop_o,
   output logic                 eop_o,
   output logic                 val_o,
   input  logic                 ready_i,
   input  logic                 clr_stat_i,
   output logic                 err_o,
   output logic [1:0]           err_code_o,
   output logic [CNT_WIDTH-1:0] pkt_cnt_o,
   output logic [CNT_WIDTH-1:0] err_cnt_o
);

   typedef struct packed {
      logic [DWIDTH-1:0] data;
      logic              sop;
      logic              eop;
   } pkt_beat_t;

   localparam int BW = $bits(pkt_beat_t);

   pkt_beat_t            beat_in, beat_out;
   logic                 orphan, no_eop, drop_beat, push_val;
   logic                 in_xfer, out_xfer;
   logic                 in_pkt_q, in_pkt_d;
   logic                 err_q, err_d;
   pkt_err_t             err_code_q, err_code_d;
   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   assign beat_in   = {data_i, sop_i, eop_i};
   assign orphan    = is_orphan(sop_i, in_pkt_q);
   assign no_eop    = is_missing_eop(sop_i, in_pkt_q);
   assign drop_beat = DROP_ORPHANS & val_i & orphan;
   assign push_val  = val_i & ~drop_beat;

   generate
      if (STAGES == 0) begin : g_wire
         assign ready_o  = ready_i | drop_beat;
         assign val_o    = push_val;
         assign beat_out = beat_in;
      end else begin : g_stages
         logic [BW-1:0] stg_data [STAGES+1];
         logic [STAGES:0] stg_val;
         logic [STAGES:0] stg_rdy;

         assign stg_data[0]     = beat_in;
         assign stg_val[0]      = push_val;
         assign ready_o         = stg_rdy[0];
         assign stg_rdy[STAGES] = ready_i;
         assign beat_out        = stg_data[STAGES];
         assign val_o           = stg_val[STAGES];

         for (genvar i = 0; i < STAGES; i++) begin : g_stage
            pkt_skid_stage #(.WIDTH(BW)) u_stage (
               .clk_i   (clk_i),
               .rst_n_i (rst_n_i),
               .data_i  (stg_data[i]),
               .val_i   (stg_val[i]),
               .ready_o (stg_rdy[i]),
               .data_o  (stg_data[i+1]),
               .val_o   (stg_val[i+1]),
               .ready_i (stg_rdy[i+1])
            );
         end
      end
   endgenerate

   assign data_o   = beat_out.data;
   assign sop_o    = beat_out.sop;
   assign eop_o    = beat_out.eop;
   assign in_xfer  = val_i & ready_o;
   assign out_xfer = val_o & ready_i & eop_o;

   // Packet tracking, error classification and saturating statistics
   always_comb begin
      in_pkt_d   = in_pkt_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      pkt_cnt_d  = pkt_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (in_xfer) begin
         in_pkt_d = sop_i ? ~eop_i : (in_pkt_q & ~eop_i);
         if (orphan) begin
            err_d      = 1'b1;
            err_code_d = ERR_ORPHAN;
         end else if (no_eop) begin
            err_d      = 1'b1;
            err_code_d = ERR_NO_EOP;
         end
      end
      if (clr_stat_i) begin
         err_cnt_d = '0;
      end else if (err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
      if (clr_stat_i) begin
         pkt_cnt_d = '0;
      end else if (out_xfer && (pkt_cnt_q != '1)) begin
         pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Checker and statistics registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         in_pkt_q   <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         in_pkt_q   <= in_pkt_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign err_o      = err_q;
   assign err_code_o = err_code_q;
   assign pkt_cnt_o  = pkt_cnt_q;
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_pkt_stream_reg_slice.sv
// Self-checking bench: instance A is the default slice (2 stages, orphans
// forwarded), instance B drops orphans and has 4-bit counters for saturation.
module tb_pkt_stream_reg_slice;

   localparam int DW  = 32;
   localparam int BDW = 8;
   localparam int BCW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;

   logic [DW-1:0]  a_data_i, a_data_o;
   logic           a_sop_i, a_eop_i, a_val_i, a_ready_o;
   logic           a_sop_o, a_eop_o, a_val_o, a_ready_i, a_clr, a_err;
   logic [1:0]     a_err_code;
   logic [15:0]    a_pkt_cnt, a_err_cnt;

   logic [BDW-1:0] b_data_i, b_data_o;
   logic           b_sop_i, b_eop_i, b_val_i, b_ready_o;
   logic           b_sop_o, b_eop_o, b_val_o, b_ready_i, b_clr, b_err;
   logic [1:0]     b_err_code;
   logic [BCW-1:0] b_pkt_cnt, b_err_cnt;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   pkt_stream_reg_slice #(.DWIDTH(DW), .STAGES(2), .DROP_ORPHANS(1'b0), .CNT_WIDTH(16)) u_dut_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .data_i(a_data_i), .sop_i(a_sop_i), .eop_i(a_eop_i), .val_i(a_val_i), .ready_o(a_ready_o),
      .data_o(a_data_o), .sop_o(a_sop_o), .eop_o(a_eop_o), .val_o(a_val_o), .ready_i(a_ready_i),
      .clr_stat_i(a_clr), .err_o(a_err), .err_code_o(a_err_code),
      .pkt_cnt_o(a_pkt_cnt), .err_cnt_o(a_err_cnt)
   );

   pkt_stream_reg_slice #(.DWIDTH(BDW), .STAGES(2), .DROP_ORPHANS(1'b1), .CNT_WIDTH(BCW)) u_dut_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .data_i(b_data_i), .sop_i(b_sop_i), .eop_i(b_eop_i), .val_i(b_val_i), .ready_o(b_ready_o),
      .data_o(b_data_o), .sop_o(b_sop_o), .eop_o(b_eop_o), .val_o(b_val_o), .ready_i(b_ready_i),
      .clr_stat_i(b_clr), .err_o(b_err), .err_code_o(b_err_code),
      .pkt_cnt_o(b_pkt_cnt), .err_cnt_o(b_err_cnt)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (a_ready_o !== 1'b0) $display("[TB] FAIL reset_ready_a: got %b want 0", a_ready_o);
      else pass_cnt++;
      chk_cnt++;
      if (b_ready_o !== 1'b0) $display("[TB] FAIL reset_ready_b: got %b want 0", b_ready_o);
      else pass_cnt++;
      chk_cnt++;
      if ({a_val_o, a_sop_o, a_eop_o, a_err, a_err_code, a_data_o, a_pkt_cnt, a_err_cnt} !== '0)
         $display("[TB] FAIL reset_outputs_a: got %h want 0",
                  {a_val_o, a_sop_o, a_eop_o, a_err, a_err_code, a_data_o, a_pkt_cnt, a_err_cnt});
      else pass_cnt++;
      chk_cnt++;
      if ({b_val_o, b_sop_o, b_eop_o, b_err, b_err_code, b_data_o, b_pkt_cnt, b_err_cnt} !== '0)
         $display("[TB] FAIL reset_outputs_b: got %h want 0",
                  {b_val_o, b_sop_o, b_eop_o, b_err, b_err_code, b_data_o, b_pkt_cnt, b_err_cnt});
      else pass_cnt++;
      rst_n = 1'b1;
      #1;
      chk_cnt++;
      if (a_ready_o !== 1'b0) $display("[TB] FAIL release_ready_before_clk: got %b want 0", a_ready_o);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (a_ready_o !== 1'b1) $display("[TB] FAIL release_ready_a: got %b want 1", a_ready_o);
      else pass_cnt++;
      chk_cnt++;
      if (b_ready_o !== 1'b1) $display("[TB] FAIL release_ready_b: got %b want 1", b_ready_o);
      else pass_cnt++;
      chk_cnt++;
      if ({a_val_o, a_err, a_pkt_cnt, a_err_cnt} !== '0)
         $display("[TB] FAIL release_outputs_a: got %h want 0", {a_val_o, a_err, a_pkt_cnt, a_err_cnt});
      else pass_cnt++;
   endtask

   task automatic test_eight_beat();
      logic [DW-1:0] want_data;
      a_ready_i = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         chk_cnt++;
         if (a_val_o !== ((j >= 2) && (j <= 9)))
            $display("[TB] FAIL eight_beat_val cyc %0d: got %b want %b", j, a_val_o, (j >= 2) && (j <= 9));
         else pass_cnt++;
         if ((j >= 2) && (j <= 9)) begin
            want_data = DW'(32'h10 + 32'(j - 2));
            chk_cnt++;
            if ({a_data_o, a_sop_o, a_eop_o} !== {want_data, 1'(j == 2), 1'(j == 9)})
               $display("[TB] FAIL eight_beat_data cyc %0d: got %h/%b/%b want %h/%b/%b", j,
                        a_data_o, a_sop_o, a_eop_o, want_data, j == 2, j == 9);
            else pass_cnt++;
         end
         if (j < 8) begin
            chk_cnt++;
            if (a_ready_o !== 1'b1) $display("[TB] FAIL eight_beat_ready cyc %0d: got %b want 1", j, a_ready_o);
            else pass_cnt++;
            a_val_i  = 1'b1;
            a_data_i = DW'(32'h10 + 32'(j));
            a_sop_i  = (j == 0);
            a_eop_i  = (j == 7);
         end else begin
            a_val_i = 1'b0;
            a_sop_i = 1'b0;
            a_eop_i = 1'b0;
         end
      end
      @(negedge clk);
      chk_cnt++;
      if (a_pkt_cnt !== 16'd1) $display("[TB] FAIL eight_beat_pkt_cnt: got %0d want 1", a_pkt_cnt);
      else pass_cnt++;
   endtask

   task automatic test_random_stream(input int n_pkts);
      beat_t src[$];
      beat_t exp_q[$];
      beat_t want;
      int    len;
      int    cyc;
      logic  rdy_before;
      for (int p = 0; p < n_pkts; p++) begin
         len = int'($urandom_range(1, 64));
         for (int b = 0; b < len; b++)
            src.push_back('{data: $urandom, sop: (b == 0), eop: (b == len - 1)});
      end
      cyc = 0;
      while ((src.size() != 0 || exp_q.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         rdy_before = a_ready_o;
         a_ready_i  = 1'($urandom_range(0, 1));
         if (src.size() != 0 && $urandom_range(0, 3) != 0) begin
            a_val_i = 1'b1;
            {a_data_i, a_sop_i, a_eop_i} = src[0];
         end else begin
            a_val_i  = 1'b0;
            a_data_i = $urandom;
            a_sop_i  = 1'($urandom_range(0, 1));
            a_eop_i  = 1'($urandom_range(0, 1));
         end
         #1;
         chk_cnt++;
         if (a_ready_o !== rdy_before)
            $display("[TB] FAIL random_ready_comb cyc %0d: got %b want %b", cyc, a_ready_o, rdy_before);
         else pass_cnt++;
         if (a_val_o && a_ready_i) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL random_extra_beat cyc %0d: got %h want none", cyc, a_data_o);
            end else begin
               want = exp_q.pop_front();
               if ({a_data_o, a_sop_o, a_eop_o} !== want)
                  $display("[TB] FAIL random_beat cyc %0d: got %h/%b/%b want %h/%b/%b", cyc,
                           a_data_o, a_sop_o, a_eop_o, want.data, want.sop, want.eop);
               else pass_cnt++;
            end
         end
         if (a_val_i && a_ready_o) exp_q.push_back(src.pop_front());
      end
      a_val_i   = 1'b0;
      a_sop_i   = 1'b0;
      a_eop_i   = 1'b0;
      a_ready_i = 1'b1;
      chk_cnt++;
      if (src.size() != 0 || exp_q.size() != 0)
         $display("[TB] FAIL random_drain: got %0d/%0d beats left want 0/0", src.size(), exp_q.size());
      else pass_cnt++;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (a_pkt_cnt !== 16'(1 + n_pkts)) $display("[TB] FAIL random_pkt_cnt: got %0d want %0d", a_pkt_cnt, 1 + n_pkts);
      else pass_cnt++;
      chk_cnt++;
      if (a_err_cnt !== 16'd0) $display("[TB] FAIL random_err_cnt: got %0d want 0", a_err_cnt);
      else pass_cnt++;
   endtask

   task automatic test_no_eop_error();
      beat_t seq[4];
      beat_t exp_q[$];
      beat_t want;
      seq[0] = '{data: 32'hA1, sop: 1'b1, eop: 1'b0};
      seq[1] = '{data: 32'hA2, sop: 1'b0, eop: 1'b0};
      seq[2] = '{data: 32'hA3, sop: 1'b1, eop: 1'b0};
      seq[3] = '{data: 32'hA4, sop: 1'b0, eop: 1'b1};
      a_ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (a_val_o) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL no_eop_extra_beat cyc %0d: got %h want none", j, a_data_o);
            end else begin
               want = exp_q.pop_front();
               if ({a_data_o, a_sop_o, a_eop_o} !== want)
                  $display("[TB] FAIL no_eop_beat cyc %0d: got %h/%b/%b want %h/%b/%b", j,
                           a_data_o, a_sop_o, a_eop_o, want.data, want.sop, want.eop);
               else pass_cnt++;
            end
         end
         if (j == 2 || j == 4) begin
            chk_cnt++;
            if (a_err !== 1'b0) $display("[TB] FAIL no_eop_err_quiet cyc %0d: got %b want 0", j, a_err);
            else pass_cnt++;
         end
         if (j == 3) begin
            chk_cnt++;
            if ({a_err, a_err_code, a_err_cnt} !== {1'b1, 2'd1, 16'd1})
               $display("[TB] FAIL no_eop_err: got err=%b code=%0d cnt=%0d want 1/1/1", a_err, a_err_code, a_err_cnt);
            else pass_cnt++;
         end
         if (j < 4) begin
            chk_cnt++;
            if (a_ready_o !== 1'b1) $display("[TB] FAIL no_eop_ready cyc %0d: got %b want 1", j, a_ready_o);
            else pass_cnt++;
            a_val_i = 1'b1;
            {a_data_i, a_sop_i, a_eop_i} = seq[j];
            exp_q.push_back(seq[j]);
         end else begin
            a_val_i = 1'b0;
            a_sop_i = 1'b0;
            a_eop_i = 1'b0;
         end
      end
      chk_cnt++;
      if (exp_q.size() != 0) $display("[TB] FAIL no_eop_missing: got %0d beats left want 0", exp_q.size());
      else pass_cnt++;
      chk_cnt++;
      if (a_err_cnt !== 16'd1) $display("[TB] FAIL no_eop_err_cnt_final: got %0d want 1", a_err_cnt);
      else pass_cnt++;
   endtask

   task automatic test_drop_orphans();
      int accepted = 0;
      b_ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk_cnt++;
         if (b_val_o !== 1'b0) $display("[TB] FAIL drop_val_o cyc %0d: got %b want 0", j, b_val_o);
         else pass_cnt++;
         if (j < 3) begin
            if (b_ready_o) accepted++;
            b_val_i  = 1'b1;
            b_data_i = BDW'($urandom);
            b_sop_i  = 1'b0;
            b_eop_i  = (j == 2);
         end else begin
            b_val_i = 1'b0;
            b_eop_i = 1'b0;
         end
      end
      chk_cnt++;
      if (accepted != 3) $display("[TB] FAIL drop_accepted: got %0d want 3", accepted);
      else pass_cnt++;
      chk_cnt++;
      if ({b_err_cnt, b_err_code} !== {4'd3, 2'd2})
         $display("[TB] FAIL drop_err_stats: got cnt=%0d code=%0d want 3/2", b_err_cnt, b_err_code);
      else pass_cnt++;
   endtask

   task automatic test_counter_saturate();
      int sent = 0;
      int waited;
      @(negedge clk);
      b_clr = 1'b1;
      @(negedge clk);
      b_clr = 1'b0;
      chk_cnt++;
      if ({b_pkt_cnt, b_err_cnt} !== '0)
         $display("[TB] FAIL sat_clear: got pkt=%0d err=%0d want 0/0", b_pkt_cnt, b_err_cnt);
      else pass_cnt++;
      b_ready_i = 1'b1;
      for (int round = 0; round < 2; round++) begin
         for (int j = 0; j < (round == 0 ? 15 : 1); j++) begin
            @(negedge clk);
            if (b_ready_o) sent++;
            b_val_i  = 1'b1;
            b_data_i = BDW'($urandom);
            b_sop_i  = 1'b1;
            b_eop_i  = 1'b1;
         end
         @(negedge clk);
         b_val_i = 1'b0;
         repeat (4) @(negedge clk);
         chk_cnt++;
         if (b_pkt_cnt !== BCW'(sent > 15 ? 15 : sent))
            $display("[TB] FAIL sat_pkt_cnt round %0d: got %0d want %0d", round, b_pkt_cnt, sent > 15 ? 15 : sent);
         else pass_cnt++;
      end
      b_ready_i = 1'b0;
      b_val_i   = 1'b1;
      b_data_i  = 8'h5C;
      @(negedge clk);
      b_val_i = 1'b0;
      waited  = 0;
      while (!b_val_o && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk_cnt++;
      if (b_val_o !== 1'b1) $display("[TB] FAIL sat_stall_timeout: got val_o=%b want 1", b_val_o);
      else pass_cnt++;
      b_ready_i = 1'b1;
      b_clr     = 1'b1;
      @(negedge clk);
      b_clr = 1'b0;
      chk_cnt++;
      if (b_pkt_cnt !== '0) $display("[TB] FAIL sat_clr_wins: got %0d want 0", b_pkt_cnt);
      else pass_cnt++;
      chk_cnt++;
      if (b_val_o !== 1'b0) $display("[TB] FAIL sat_clr_beat_sent: got val_o=%b want 0", b_val_o);
      else pass_cnt++;
   endtask

   // Abort guard so a stuck design still ends the run
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: time limit reached, got no completion want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      a_data_i  = '0; a_sop_i = 1'b0; a_eop_i = 1'b0; a_val_i = 1'b0; a_ready_i = 1'b1; a_clr = 1'b0;
      b_data_i  = '0; b_sop_i = 1'b0; b_eop_i = 1'b0; b_val_i = 1'b0; b_ready_i = 1'b1; b_clr = 1'b0;
      $display("[TB] starting pkt_stream_reg_slice bench");
      test_reset();
      test_eight_beat();
      test_random_stream(300);
      test_no_eop_error();
      test_drop_orphans();
      test_counter_saturate();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
